// File: rtl/controlador_bus.sv
// CPU-side sequencer for the CPUCR memory bus: byte/word read and write requests
// become byte transfers on Direccion/Datos, with LE low as the memory write strobe.
module controlador_bus #(
  parameter int unsigned MAYOR_PRIMERO  = 0,
  parameter int unsigned ESPERA_LECTURA = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Inicio,
  input  logic        Escribir,
  input  logic        Palabra,
  input  logic [15:0] DirIn,
  input  logic [15:0] DatoEsc,
  output logic        Listo,
  output logic        Hecho,
  output logic [15:0] DatoLeido,
  output logic [15:0] Direccion,
  output logic        LE,
  inout  logic [7:0]  Datos
);

  localparam logic [3:0] ESPERA = ESPERA_LECTURA[3:0];
  localparam logic       MAYOR  = (MAYOR_PRIMERO != 0);

  typedef enum logic [3:0] {
    IDLE, LEE0, LEE1, FIN, PREP0, BAJO0, SUBE0, PREP1, BAJO1, SUBE1
  } estado_t;

  estado_t     estado_q, estado_d;
  logic        palabra_q, palabra_d;
  logic        le_q, le_d;
  logic [3:0]  espera_q, espera_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  segundo_q, segundo_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [15:0] direccion_q, direccion_d;
  logic [15:0] dato_leido_q, dato_leido_d;

  always_comb begin
    estado_d     = estado_q;
    palabra_d    = palabra_q;
    espera_d     = espera_q;
    byte_d       = byte_q;
    segundo_d    = segundo_q;
    byte0_d      = byte0_q;
    direccion_d  = direccion_q;
    dato_leido_d = dato_leido_q;
    case (estado_q)
      IDLE: begin
        if (Inicio) begin
          direccion_d = DirIn;
          palabra_d   = Palabra;
          byte_d      = MAYOR ? DatoEsc[15:8] : DatoEsc[7:0];
          segundo_d   = MAYOR ? DatoEsc[7:0]  : DatoEsc[15:8];
          espera_d    = '0;
          estado_d    = Escribir ? PREP0 : LEE0;
        end
      end
      LEE0, LEE1: begin
        if (espera_q != ESPERA) begin
          espera_d = espera_q + 4'd1;
        end else begin
          espera_d = '0;
          if (estado_q == LEE0 && palabra_q) begin
            byte0_d     = Datos;
            direccion_d = direccion_q + 16'd1;
            estado_d    = LEE1;
          end else begin
            // byte0_q holds the byte from A, Datos the byte from A+1
            if (estado_q == LEE0)
              dato_leido_d = {8'h00, Datos};
            else if (MAYOR)
              dato_leido_d = {byte0_q, Datos};
            else
              dato_leido_d = {Datos, byte0_q};
            estado_d = FIN;
          end
        end
      end
      PREP0: estado_d = BAJO0;
      BAJO0: estado_d = SUBE0;
      SUBE0: begin
        if (palabra_q) begin
          direccion_d = direccion_q + 16'd1;
          byte_d      = segundo_q;
          estado_d    = PREP1;
        end else begin
          estado_d = FIN;
        end
      end
      PREP1: estado_d = BAJO1;
      BAJO1: estado_d = SUBE1;
      SUBE1: estado_d = FIN;
      FIN:   estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
    le_d = !(estado_d == BAJO0 || estado_d == BAJO1);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      estado_q     <= IDLE;
      palabra_q    <= 1'b0;
      le_q         <= 1'b1;
      espera_q     <= '0;
      byte_q       <= '0;
      segundo_q    <= '0;
      byte0_q      <= '0;
      direccion_q  <= '0;
      dato_leido_q <= '0;
    end else begin
      estado_q     <= estado_d;
      palabra_q    <= palabra_d;
      le_q         <= le_d;
      espera_q     <= espera_d;
      byte_q       <= byte_d;
      segundo_q    <= segundo_d;
      byte0_q      <= byte0_d;
      direccion_q  <= direccion_d;
      dato_leido_q <= dato_leido_d;
    end
  end

  assign Listo     = (estado_q == IDLE);
  assign Hecho     = (estado_q == FIN);
  assign DatoLeido = dato_leido_q;
  assign Direccion = direccion_q;
  assign LE        = le_q;
  assign Datos     = le_q ? 8'hzz : byte_q;

endmodule
